// File: rtl/forest_pkg.sv
// forest_pkg: shared constants and types for the tree-ensemble
// vote aggregation datapath.
package forest_pkg;

    localparam int N_FEATURES = 51;
    localparam int N_CLASSES  = 4;
    localparam int N_TREES    = 8;
    localparam int CLS_W      = $clog2(N_CLASSES);
    localparam int CNT_W      = $clog2(N_TREES + 1);
    localparam int VOTES_W    = N_CLASSES * N_TREES;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

endpackage

// File: rtl/forest_vote_argmax_popcount.sv
// vote_popcount: combinational count of set bits in one
// class's tree-vote slice.
module vote_popcount
    import forest_pkg::*;
(
    input  logic [N_TREES-1:0] bits,
    output logic [CNT_W-1:0]   cnt
);

    // ripple sum of the vote bits
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N_TREES; i++) begin
            cnt = cnt + CNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/forest_vote_argmax.sv
// forest_vote_argmax: captures one vote vector, counts votes
// per class one class per cycle and reports the argmax.
module forest_vote_argmax
    import forest_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [VOTES_W-1:0] votes,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLS_W-1:0]   out_class,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_tie
);

    localparam logic [CLS_W-1:0] LAST = CLS_W'(N_CLASSES - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CLS_W-1:0]   idx_q;
    logic [VOTES_W-1:0] votes_q;
    logic [CLS_W-1:0]   best_class_q;
    logic [CNT_W-1:0]   best_cnt_q;
    logic               tie_q;
    logic [CLS_W-1:0]   nb_class;
    logic [CNT_W-1:0]   nb_cnt;
    logic               nb_tie;
    logic [N_TREES-1:0] slice;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (idx_q == LAST);
    assign slice     = votes_q[int'(idx_q) * N_TREES +: N_TREES];

    vote_popcount u_popcount (
        .bits (slice),
        .cnt  (cnt)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and running best-class update
    always_comb begin
        state_d  = state_q;
        nb_class = best_class_q;
        nb_cnt   = best_cnt_q;
        nb_tie   = tie_q;
        if (idx_q == '0) begin
            nb_class = '0;
            nb_cnt   = cnt;
            nb_tie   = 1'b0;
        end else if (cnt > best_cnt_q) begin
            nb_class = idx_q;
            nb_cnt   = cnt;
            nb_tie   = 1'b0;
        end else if (cnt == best_cnt_q) begin
            nb_tie   = 1'b1;
        end
        unique case (state_q)
            IDLE:    if (accept) state_d = COUNT;
            COUNT:   if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // capture, per-class accumulation and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            votes_q      <= '0;
            idx_q        <= '0;
            best_class_q <= '0;
            best_cnt_q   <= '0;
            tie_q        <= 1'b0;
            out_class    <= '0;
            out_count    <= '0;
            out_tie      <= 1'b0;
        end else begin
            if (state_q == IDLE && accept) begin
                votes_q <= votes;
                idx_q   <= '0;
            end
            if (state_q == COUNT) begin
                best_class_q <= nb_class;
                best_cnt_q   <= nb_cnt;
                tie_q        <= nb_tie;
                if (last) begin
                    out_class <= nb_class;
                    out_count <= nb_cnt;
                    out_tie   <= nb_tie;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_forest_vote_argmax.sv
// tb_forest_vote_argmax: directed vectors with hand-computed
// argmax results for forest_vote_argmax.
module tb_forest_vote_argmax;
    import forest_pkg::*;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [VOTES_W-1:0] votes;
    logic               out_valid;
    logic               out_ready;
    logic [CLS_W-1:0]   out_class;
    logic [CNT_W-1:0]   out_count;
    logic               out_tie;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    forest_vote_argmax dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .votes     (votes),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_count (out_count),
        .out_tie   (out_tie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // wait for in_ready, present v for one accept edge
    task automatic accept(input logic [31:0] v);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(in_ready), 1);
        votes    = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        votes    = ~v;
    endtask

    // edges from accept until out_valid is seen
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
        if (!out_valid) check("valid_timeout", 0, 1);
    endtask

    task automatic expect_res(input string tag,
                              input int c,
                              input int n,
                              input int t);
        check({tag, "_class"}, 32'(out_class), c);
        check({tag, "_count"}, 32'(out_count), n);
        check({tag, "_tie"}, 32'(out_tie), t);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("take_valid", 32'(out_valid), 0);
        check("take_ready", 32'(in_ready), 1);
    endtask

    task automatic run(input string tag,
                       input logic [31:0] v,
                       input int c,
                       input int n,
                       input int t);
        int lat;
        accept(v);
        wait_valid(lat);
        check({tag, "_lat"}, lat, 4);
        expect_res(tag, c, n, t);
        take();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int t0;
        logic [CLS_W-1:0] hc;
        logic [CNT_W-1:0] hn;
        logic ht;
        logic [31:0] b2b_v [3];
        int b2b_c [3];
        int b2b_t [3];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        votes     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        expect_res("rst", 0, 0, 0);
        in_valid = 1'b1;
        votes    = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_no_capture", 32'(out_valid), 0);
        check("rst_idle", 32'(in_ready), 1);

        run("t1", 32'h00FF_0000, 2, 8, 0);
        run("t2", 32'hF001_0F01, 1, 4, 1);
        run("t3", 32'h0007_0303, 2, 3, 0);
        run("t4", 32'h0000_0000, 0, 0, 1);

        // class counts 4,4,3,2 -> class0, tie
        accept(32'h1234_5678);
        wait_valid(lat);
        expect_res("t5", 0, 4, 1);
        hc = out_class;
        hn = out_count;
        ht = out_tie;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            votes    = 32'hFF00_0000;
            @(posedge clk);
            #1;
            check("t5_hold_v", 32'(out_valid), 1);
            check("t5_hold_r", 32'(in_ready), 0);
            check("t5_hold_c", 32'(out_class), 32'(hc));
            check("t5_hold_n", 32'(out_count), 32'(hn));
            check("t5_hold_t", 32'(out_tie), 32'(ht));
        end
        in_valid = 1'b0;
        take();
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_accept", 32'(out_valid), 0);

        accept(32'hFFFF_FFFF);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 0);
        check("t6_rst_ready", 32'(in_ready), 1);
        expect_res("t6_rst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t6_no_partial", 32'(out_valid), 0);
        run("t6", 32'hFF00_0000, 3, 8, 0);

        b2b_v[0] = 32'h0000_FF00;
        b2b_c[0] = 1;
        b2b_t[0] = 0;
        b2b_v[1] = 32'h0101_0101;
        b2b_c[1] = 0;
        b2b_t[1] = 1;
        b2b_v[2] = 32'h7F3F_1F0F;
        b2b_c[2] = 3;
        b2b_t[2] = 0;
        out_ready = 1'b1;
        t0 = 0;
        for (int k = 0; k < 3; k++) begin
            accept(b2b_v[k]);
            wait_valid(lat);
            check("t7_lat", lat, 4);
            check("t7_class", 32'(out_class), b2b_c[k]);
            check("t7_tie", 32'(out_tie), b2b_t[k]);
            if (k > 0) check("t7_period", cyc - t0, 6);
            t0 = cyc;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("t7_final_idle", 32'(in_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
